loop_counter_ctrl: RTL

Run controller for the free-running 7-bit loop counter datapath. It turns that counter into a programmable, sequenced resource with:
- start/stop/pause control
- a per-run terminal value (limit)
- a repeat count (loops)
- wrap and done status pulses

Upstream control logic programs a run with one start pulse; the block owns the count register and reports progress.

---
 rtl/loop_counter_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/loop_counter_ctrl.sv
// rtl/loop_counter_ctrl.sv - sequenced run controller owning the loop count register
module loop_counter_ctrl #(
    parameter int CNT_W  = 7,
    parameter int LOOP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [CNT_W-1:0]  limit,
    input  logic [LOOP_W-1:0] loops,
    output logic [CNT_W-1:0]  cnt,
    output logic [LOOP_W-1:0] loop_idx,
    output logic              busy,
    output logic              wrap,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  lim_q;
    logic [LOOP_W-1:0] loops_q;
    logic [LOOP_W-1:0] last_idx;

    // loops_q is never 0, so this cannot underflow
    assign last_idx = loops_q - LOOP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            loop_idx <= '0;
            busy     <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            lim_q    <= '0;
            loops_q  <= LOOP_W'(1);
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        lim_q    <= limit;
                        loops_q  <= (loops == '0) ? LOOP_W'(1) : loops;
                        cnt      <= '0;
                        loop_idx <= '0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        cnt      <= '0;
                        loop_idx <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (pause) begin
                        state <= S_HOLD;
                    end else if (cnt < lim_q) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (loop_idx < last_idx) begin
                        cnt      <= '0;
                        loop_idx <= loop_idx + LOOP_W'(1);
                        wrap     <= 1'b1;
                    end else begin
                        // final terminal count: cnt stays at lim_q into DONE
                        wrap  <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_HOLD: begin
                    if (stop) begin
                        cnt      <= '0;
                        loop_idx <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (!pause) begin
                        state <= S_RUN;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
